// File: rtl/clkgen_pkg.sv
// Shared types and helpers for the clock divider bank.
// Divisors below 2 cannot make a two-phase clock, so they are clamped up to 2.
package clkgen_pkg;

   localparam int DEFAULT_DIV_W = 8;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } ch_state_t;

   // Values 0 and 1 are stored as 2; everything else passes through unchanged.
   function automatic logic [31:0] clamp_div(input logic [31:0] value);
      return (value < 32'd2) ? 32'd2 : value;
   endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: shadow/active divisor, period counter, glitch-free run control.
// All outputs come straight from flops; the next-state logic computes them one cycle ahead.
module clk_div_ch
   import clkgen_pkg::*;
#(
   parameter int DIV_W       = DEFAULT_DIV_W,
   parameter int DEFAULT_DIV = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             div_load,
   input  logic [DIV_W-1:0] div_val,
   input  logic             sync,
   output logic             clk_out,
   output logic             tick,
   output logic             running
);

   localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(clamp_div(32'(DEFAULT_DIV)));

   ch_state_t        r_state;
   logic [DIV_W-1:0] r_cnt;
   logic [DIV_W-1:0] r_shadow;
   logic [DIV_W-1:0] r_active;
   logic             r_clk_out;
   logic             r_tick;

   ch_state_t        w_state_next;
   logic [DIV_W-1:0] w_cnt_next;
   logic [DIV_W-1:0] w_shadow_next;
   logic [DIV_W-1:0] w_active_next;
   logic             w_clk_out_next;
   logic             w_tick_next;
   logic [DIV_W-1:0] w_div_clamped;
   logic             w_start;
   logic             w_boundary;
   logic             w_restart;
   logic             w_load_evt;

   assign w_div_clamped = DIV_W'(clamp_div(32'(div_val)));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_shadow  <= RST_DIV;
         r_active  <= RST_DIV;
         r_clk_out <= 1'b0;
         r_tick    <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_cnt     <= w_cnt_next;
         r_shadow  <= w_shadow_next;
         r_active  <= w_active_next;
         r_clk_out <= w_clk_out_next;
         r_tick    <= w_tick_next;
      end
   end

   always_comb begin
      w_start       = (r_state == IDLE) && en;
      w_boundary    = (r_state == RUN) && (r_cnt == (r_active - DIV_W'(1)));
      w_restart     = sync && ((r_state == RUN) || en);
      w_load_evt    = w_start || w_boundary || w_restart;

      w_state_next  = r_state;
      w_cnt_next    = r_cnt;
      w_shadow_next = div_load ? w_div_clamped : r_shadow;
      w_active_next = r_active;

      // A divisor written on the same cycle as a reload bypasses the shadow.
      if (w_load_evt) begin
         w_active_next = div_load ? w_div_clamped : r_shadow;
      end

      if (w_start || w_restart) begin
         w_state_next = RUN;
         w_cnt_next   = '0;
      end else if (r_state == RUN) begin
         if (w_boundary) begin
            w_cnt_next = '0;
            if (!en) begin
               w_state_next = IDLE;
            end
         end else begin
            w_cnt_next = r_cnt + DIV_W'(1);
         end
      end

      // In RUN the counter only returns to 0 at the start of a new period.
      w_clk_out_next = (w_state_next == RUN) && (w_cnt_next < (w_active_next >> 1));
      w_tick_next    = (w_state_next == RUN) && (w_cnt_next == '0);
   end

   assign clk_out = r_clk_out;
   assign tick    = r_tick;
   assign running = (r_state == RUN);

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH independent programmable clock dividers sharing one system clock.
// A single sync pulse is fanned out so all running channels restart in phase.
module clk_div_bank
   import clkgen_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int DIV_W       = DEFAULT_DIV_W,
   parameter int DEFAULT_DIV = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_CH-1:0]       en,
   input  logic [NUM_CH-1:0]       div_load,
   input  logic [NUM_CH*DIV_W-1:0] div_val,
   input  logic                    sync,
   output logic [NUM_CH-1:0]       clk_out,
   output logic [NUM_CH-1:0]       tick,
   output logic [NUM_CH-1:0]       running
);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         clk_div_ch #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
         ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .en       (en[gi]),
            .div_load (div_load[gi]),
            .div_val  (div_val[gi*DIV_W +: DIV_W]),
            .sync     (sync),
            .clk_out  (clk_out[gi]),
            .tick     (tick[gi]),
            .running  (running[gi])
         );
      end
   endgenerate

endmodule
